// File: rtl/riscv_pkg.sv
// Shared front-end definitions.
// fetch_entry_t is the {pc, instr} record buffered by the fetch queue in the
// default 16-bit PC / 32-bit instruction configuration. The default
// constants seed the fetch_queue parameters.
package riscv_pkg;

  localparam int PC_WIDTH_DEFAULT    = 16;
  localparam int INSTR_WIDTH_DEFAULT = 32;
  localparam int PC_STEP_DEFAULT     = 4;
  localparam int RESET_PC_DEFAULT    = 0;

  typedef struct packed {
    logic [PC_WIDTH_DEFAULT-1:0]    pc;
    logic [INSTR_WIDTH_DEFAULT-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a flush that empties it at the next edge.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset (control only)
//   push, wdata   - write request and data
//   pop           - read request; rdata shows the head
//   flush         - clear pointers and occupancy; overrides push/pop
//   count         - occupancy, full/empty flags
// DEPTH must be a power of 2 so the pointers wrap naturally.
module sync_fifo
  import riscv_pkg::*;
#(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Protect the occupancy count against a caller that over- or under-runs.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wr_ptr] <= wdata;
  end

  // Empty reads return zero so stale or uninitialised storage never leaks out.
  assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, drives the instruction
// memory address, and buffers fetched {pc, instr} pairs for decode.
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   fetch_en                    - allow fetching; 0 holds the PC
//   imem_addr / imem_rdata      - combinational instruction-memory port
//   redirect_valid/redirect_pc  - branch/jump restart; flushes the queue
//   out_valid/out_ready         - head handshake toward decode
//   out_instr/out_pc/out_pc_plus- head entry and its link value
//   count, full                 - queue occupancy
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int PC_WIDTH    = PC_WIDTH_DEFAULT,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEFAULT,
  parameter int DEPTH       = 4,
  parameter int RESET_PC    = RESET_PC_DEFAULT,
  parameter int PC_STEP     = PC_STEP_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic [PC_WIDTH-1:0]        imem_addr,
  input  logic [INSTR_WIDTH-1:0]     imem_rdata,
  input  logic                       redirect_valid,
  input  logic [PC_WIDTH-1:0]        redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [PC_WIDTH-1:0]        out_pc_plus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam logic [PC_WIDTH-1:0] STEP     = PC_WIDTH'(PC_STEP);
  localparam logic [PC_WIDTH-1:0] PC_RESET = PC_WIDTH'(RESET_PC);
  localparam logic [PC_WIDTH-1:0] ALIGN    = ~PC_WIDTH'(3);

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [PC_WIDTH-1:0] fetch_pc;
  logic                pop;
  logic                push;
  logic                empty;
  entry_t              wr_entry;
  entry_t              head;

  assign pop  = out_valid && out_ready;
  // Redirect squashes the instruction currently being fetched.
  assign push = fetch_en && !redirect_valid && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 fetch_pc <= PC_RESET;
    else if (redirect_valid) fetch_pc <= redirect_pc & ALIGN;
    else if (push)           fetch_pc <= fetch_pc + STEP;
  end

  assign imem_addr = fetch_pc;
  assign wr_entry  = '{pc: fetch_pc, instr: imem_rdata};

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wr_entry),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_valid   = !empty;
  assign out_instr   = head.instr;
  assign out_pc      = head.pc;
  assign out_pc_plus = head.pc + STEP;

endmodule
